// File: rtl/fpga1_transmitter.sv
// Sender side of the FPGA1->FPGA2 burst link: buffers BURST_LEN words, then runs req/rdy/send_done/ack.
// Optional even parity on data_out is enabled with `define F2F_TX_PARITY_EN.
module fpga1_transmitter #(
    parameter int BURST_LEN      = 8,
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] data_out,
    output logic        req_out,
    output logic        send_done,
    input  logic        rdy_in,
    input  logic        ack_in,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_abort,
    output logic [15:0] burst_cnt
`ifdef F2F_TX_PARITY_EN
    ,
    output logic        data_par_out
`endif
);
    localparam int CNT_W   = $clog2(BURST_LEN + 1);
    localparam int PTR_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TMO_MAX = (TIMEOUT_CYCLES > BACKOFF_CYCLES) ? TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int TMO_W   = $clog2(TMO_MAX + 1);

    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(BURST_LEN);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(BURST_LEN - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]  BO_LAST   = TMO_W'(BACKOFF_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, REQ, SEND, WAIT_ACK, BACKOFF} state_t;
    state_t state;

    logic              rdy_q, rdy_s, ack_q, ack_s;
    logic [31:0]       mem [BURST_LEN];
    logic [CNT_W-1:0]  wr_cnt;
    logic [PTR_W-1:0]  rd_ptr, next_ptr;
    logic [HOLD_W-1:0] hold;
    logic [TMO_W-1:0]  tmo;
    logic              rdy_low_seen;
    logic              load;
    logic [31:0]       load_word;

    assign s_ready  = (state == IDLE) && (wr_cnt != FULL);
    assign busy     = (state != IDLE);
    assign next_ptr = rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b0;
            rdy_s <= 1'b0;
            ack_q <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            rdy_q <= rdy_in;
            rdy_s <= rdy_q;
            ack_q <= ack_in;
            ack_s <= ack_q;
        end
    end

    // Buffer contents are not reset; wr_cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (s_valid && s_ready)
            mem[wr_cnt[PTR_W-1:0]] <= s_data;
    end

    always_comb begin
        load      = 1'b0;
        load_word = mem[0];
        if (state == REQ && rdy_s) begin
            load = 1'b1;
        end else if (state == SEND && rdy_s && hold == LAST_HOLD && rd_ptr != LAST_PTR) begin
            load      = 1'b1;
            load_word = mem[next_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
`ifdef F2F_TX_PARITY_EN
            data_par_out <= 1'b0;
`endif
        end else if (load) begin
            data_out <= load_word;
`ifdef F2F_TX_PARITY_EN
            data_par_out <= ^load_word;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            rd_ptr       <= '0;
            hold         <= '0;
            tmo          <= '0;
            req_out      <= 1'b0;
            send_done    <= 1'b0;
            err_timeout  <= 1'b0;
            err_abort    <= 1'b0;
            burst_cnt    <= '0;
            rdy_low_seen <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            err_abort   <= 1'b0;
            // A fresh burst needs rdy to have been seen low since the last ack.
            if (!rdy_s)
                rdy_low_seen <= 1'b1;
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    end else if (wr_cnt == FULL && rdy_low_seen) begin
                        state   <= REQ;
                        req_out <= 1'b1;
                        tmo     <= '0;
                    end
                end
                REQ: begin
                    if (rdy_s) begin
                        state  <= SEND;
                        rd_ptr <= '0;
                        hold   <= '0;
                    end else if (tmo == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= BACKOFF;
                        req_out     <= 1'b0;
                        tmo         <= '0;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                SEND: begin
                    if (!rdy_s) begin
                        err_abort <= 1'b1;
                        state     <= BACKOFF;
                        req_out   <= 1'b0;
                        tmo       <= '0;
                    end else if (hold == LAST_HOLD) begin
                        hold <= '0;
                        if (rd_ptr == LAST_PTR) begin
                            state     <= WAIT_ACK;
                            send_done <= 1'b1;
                            tmo       <= '0;
                        end else begin
                            rd_ptr <= next_ptr;
                        end
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                end
                WAIT_ACK: begin
                    if (ack_s) begin
                        state        <= IDLE;
                        req_out      <= 1'b0;
                        send_done    <= 1'b0;
                        burst_cnt    <= burst_cnt + 16'd1;
                        wr_cnt       <= '0;
                        rdy_low_seen <= 1'b0;
                    end else if (tmo == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= BACKOFF;
                        req_out     <= 1'b0;
                        send_done   <= 1'b0;
                        tmo         <= '0;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                BACKOFF: begin
                    if (tmo == BO_LAST) begin
                        state   <= REQ;
                        req_out <= 1'b1;
                        tmo     <= '0;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpga1_transmitter.sv
// Directed-plus-random bench for fpga1_transmitter: normal bursts, stale ack, timeout,
// abort/resend, reset mid-send and burst counter wrap, checked against a word-queue model.
module tb_fpga1_transmitter;
    localparam int B  = 4;
    localparam int H  = 4;
    localparam int T  = 1024;
    localparam int BO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] data_out;
    logic        req_out;
    logic        send_done;
    logic        rdy_in;
    logic        ack_in;
    logic        busy;
    logic        err_timeout;
    logic        err_abort;
    logic [15:0] burst_cnt;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_bursts;

    always #5 clk = ~clk;

    fpga1_transmitter #(
        .BURST_LEN(B), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T), .BACKOFF_CYCLES(BO)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .data_out(data_out), .req_out(req_out), .send_done(send_done),
        .rdy_in(rdy_in), .ack_in(ack_in), .busy(busy),
        .err_timeout(err_timeout), .err_abort(err_abort), .burst_cnt(burst_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic sig(input int k);
        case (k)
            0:       return req_out;
            1:       return send_done;
            2:       return err_abort;
            3:       return err_timeout;
            4:       return busy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int k, input logic val, input int bound);
        int t = 0;
        while (sig(k) !== val && t < bound) begin
            tick();
            t++;
        end
        check(tag, {31'd0, sig(k)}, {31'd0, val});
    endtask

    task automatic push_burst(input bit directed);
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < B; i++) begin
            w = directed ? 32'(i + 1) : $urandom;
            exp_q.push_back(w);
            repeat ($urandom_range(0, 2)) tick();
            for (int t = 0; t < 50 && !s_ready; t++) tick();
            s_data  = w;
            s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
        end
        check("s_ready_full", {31'd0, s_ready}, 32'd0);
    endtask

    // Raise rdy and record data_out until send_done; two stale samples precede the burst.
    task automatic capture_burst(input string tag);
        logic [31:0] obs[$];
        int t = 0;
        rdy_in = 1'b1;
        while (t < 100) begin
            tick();
            t++;
            if (send_done) break;
            obs.push_back(data_out);
        end
        check({tag, "_done"}, {31'd0, send_done}, 32'd1);
        check({tag, "_len"}, obs.size(), 2 + B * H);
        for (int i = 0; i < B * H; i++)
            if (i + 2 < obs.size())
                check({tag, "_word"}, obs[i + 2], exp_q[i / H]);
        check({tag, "_last_held"}, data_out, exp_q[B - 1]);
    endtask

    task automatic ack_pulse();
        ack_in = 1'b1;
        rdy_in = 1'b0;
        tick();
        ack_in = 1'b0;
        exp_bursts = exp_bursts + 16'd1;
        wait_sig("idle_after_ack", 4, 1'b0, 3);
        check("s_ready_after_ack", {31'd0, s_ready}, 32'd1);
        check("send_done_after_ack", {31'd0, send_done}, 32'd0);
        check("burst_cnt", {16'd0, burst_cnt}, {16'd0, exp_bursts});
    endtask

    initial begin
        int n;
        rst = 1'b1; s_data = '0; s_valid = 1'b0; rdy_in = 1'b0; ack_in = 1'b0;
        exp_bursts = '0;
        repeat (3) tick();
        check("rst_req", {31'd0, req_out}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_burst_cnt", {16'd0, burst_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_s_ready", {31'd0, s_ready}, 32'd1);
        check("idle_send_done", {31'd0, send_done}, 32'd0);
        check("idle_errs", {30'd0, err_timeout, err_abort}, 32'd0);

        // Directed burst 1,2,3,4 with rdy 10 cycles after req
        push_burst(1'b1);
        wait_sig("req_rise", 0, 1'b1, 5);
        repeat (10) tick();
        capture_burst("directed");
        repeat (5) tick();
        check("send_done_hold", {31'd0, send_done}, 32'd1);
        check("req_in_wait_ack", {31'd0, req_out}, 32'd1);
        ack_pulse();

        // Random bursts; the first one also gets a stale ack while in REQ
        for (int k = 0; k < 3; k++) begin
            push_burst(1'b0);
            wait_sig("req_rise_rand", 0, 1'b1, 5);
            if (k == 0) begin
                ack_in = 1'b1;
                tick();
                ack_in = 1'b0;
                repeat (5) tick();
                check("stale_ack_busy", {31'd0, busy}, 32'd1);
                check("stale_ack_req", {31'd0, req_out}, 32'd1);
                check("stale_ack_cnt", {16'd0, burst_cnt}, {16'd0, exp_bursts});
            end
            repeat ($urandom_range(0, 20)) tick();
            capture_burst("random");
            ack_pulse();
        end

        // rdy never rises: timeout, backoff, then the same burst is resent
        push_burst(1'b0);
        wait_sig("req_rise_tmo", 0, 1'b1, 5);
        n = 0;
        while (req_out && n < 2000) begin
            n++;
            tick();
        end
        check("tmo_req_cycles", n, T);
        check("tmo_pulse", {31'd0, err_timeout}, 32'd1);
        n = 0;
        while (!req_out && n < 100) begin
            n++;
            tick();
            if (n == 1) check("tmo_pulse_width", {31'd0, err_timeout}, 32'd0);
        end
        check("backoff_cycles", n, BO);
        check("tmo_cnt_unchanged", {16'd0, burst_cnt}, {16'd0, exp_bursts});
        capture_burst("after_tmo");
        ack_pulse();

        // rdy drops after word 2: abort, backoff, resend from word 1
        push_burst(1'b0);
        wait_sig("req_rise_abort", 0, 1'b1, 5);
        rdy_in = 1'b1;
        repeat (2 + 2 * H) tick();
        check("abort_word2", data_out, exp_q[1]);
        rdy_in = 1'b0;
        wait_sig("abort_pulse", 2, 1'b1, 10);
        check("abort_req_low", {31'd0, req_out}, 32'd0);
        check("abort_data_held", data_out, exp_q[2]);
        tick();
        check("abort_pulse_width", {31'd0, err_abort}, 32'd0);
        wait_sig("req_rerise", 0, 1'b1, 40);
        capture_burst("after_abort");
        ack_pulse();

        // Reset during word 3 of a send
        push_burst(1'b0);
        wait_sig("req_rise_rst", 0, 1'b1, 5);
        rdy_in = 1'b1;
        repeat (3 + 2 * H) tick();
        check("rst_mid_word3", data_out, exp_q[2]);
        rst = 1'b1;
        tick();
        check("midrst_data", data_out, 32'd0);
        check("midrst_req", {31'd0, req_out}, 32'd0);
        check("midrst_send_done", {31'd0, send_done}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_s_ready", {31'd0, s_ready}, 32'd1);
        check("midrst_burst_cnt", {16'd0, burst_cnt}, 32'd0);
        rst = 1'b0;
        rdy_in = 1'b0;
        exp_bursts = '0;
        tick();

        // Counter wrap 0xFFFF -> 0
        force dut.burst_cnt = 16'hFFFF;
        tick();
        release dut.burst_cnt;
        exp_bursts = 16'hFFFF;
        push_burst(1'b0);
        wait_sig("req_rise_wrap", 0, 1'b1, 5);
        capture_burst("wrap");
        ack_pulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
